// File: rtl/memory_controller_dma_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_controller_dma_if
// Description : CPU, main RAM/cart, PPU and I/O bus bundle of the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_controller_dma_if;
    logic [15:0] A_cpu;
    logic [7:0]  Di_cpu;
    logic [7:0]  Do_cpu;
    logic        rd_cpu_n;
    logic        wr_cpu_n;

    logic [15:0] A;
    logic [7:0]  Do;
    logic [7:0]  Di;
    logic        rd_n;
    logic        wr_n;
    logic        cs_n;

    logic [15:0] A_ppu;
    logic [7:0]  Do_ppu;
    logic [7:0]  Di_ppu;
    logic        rd_ppu_n;
    logic        wr_ppu_n;
    logic        cs_ppu;

    logic [7:0]  Do_interrupt;
    logic [7:0]  Do_timer;
    logic [7:0]  Do_sound;
    logic [7:0]  Do_joypad;
    logic        cs_interrupt;
    logic        cs_timer;
    logic        cs_sound;
    logic        cs_joypad;

    logic        dma_active;

    modport master (
        input  A_cpu, Di_cpu, rd_cpu_n, wr_cpu_n, Di, Di_ppu,
               Do_interrupt, Do_timer, Do_sound, Do_joypad,
        output Do_cpu, A, Do, rd_n, wr_n, cs_n,
               A_ppu, Do_ppu, rd_ppu_n, wr_ppu_n, cs_ppu,
               cs_interrupt, cs_timer, cs_sound, cs_joypad, dma_active
    );

    modport slave (
        output A_cpu, Di_cpu, rd_cpu_n, wr_cpu_n, Di, Di_ppu,
               Do_interrupt, Do_timer, Do_sound, Do_joypad,
        input  Do_cpu, A, Do, rd_n, wr_n, cs_n,
               A_ppu, Do_ppu, rd_ppu_n, wr_ppu_n, cs_ppu,
               cs_interrupt, cs_timer, cs_sound, cs_joypad, dma_active
    );
endinterface
`default_nettype wire

// File: rtl/memory_controller_dma.sv
`default_nettype none
// ============================================================================
// Module      : memory_controller_dma
// Description : Game Boy CPU address decoder / bus router with OAM DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_controller_dma #(
    parameter int                        BOOT_SIZE  = 256,
    parameter logic [8*BOOT_SIZE-1:0]    BOOT_IMAGE = '0,
    parameter int                        HRAM_DEPTH = 127,
    parameter int                        DMA_LEN    = 160,
    parameter int                        DMA_DELAY  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    memory_controller_dma_if.master bus
);
    localparam int          c_BOOT_AW  = $clog2(BOOT_SIZE);
    localparam logic [15:0] c_HRAM_END = 16'(32'hFF80 + HRAM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      dma_reg_q, dma_reg_d;
    logic [7:0]      latch_q, latch_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [15:0]     dly_q, dly_d;
    logic            boot_en_q, boot_en_d;
    logic            dma_active_q;
    logic [7:0]      hram_q [HRAM_DEPTH];

    logic [15:0]          w_a;
    logic                 w_cpu_wr;
    logic                 w_lock;
    logic                 w_sel_boot, w_sel_hram, w_sel_ff46, w_sel_ff50;
    logic                 w_sel_ppu, w_sel_main;
    logic                 w_sel_int, w_sel_timer, w_sel_sound, w_sel_joy;
    logic [c_BOOT_AW-1:0] w_boot_idx;
    logic [7:0]           w_boot_byte;
    logic [6:0]           w_hram_idx;
    logic [7:0]           w_src_page;
    logic [15:0]          w_src_addr;
    logic                 w_src_vram;
    logic [15:0]          w_oam_addr;

    assign w_a      = bus.A_cpu;
    assign w_cpu_wr = !bus.wr_cpu_n;
    assign w_lock   = dma_active_q;

    assign w_sel_boot  = boot_en_q && (w_a < 16'(BOOT_SIZE));
    assign w_sel_hram  = (w_a >= 16'hFF80) && (w_a < c_HRAM_END);
    assign w_sel_ff46  = (w_a == 16'hFF46);
    assign w_sel_ff50  = (w_a == 16'hFF50);
    assign w_sel_ppu   = (w_a >= 16'h8000 && w_a <= 16'h9FFF)
                      || (w_a >= 16'hFE00 && w_a <= 16'hFE9F)
                      || (w_a >= 16'hFF40 && w_a <= 16'hFF4B && !w_sel_ff46);
    assign w_sel_main  = (w_a < 16'hFE00) && !w_sel_ppu && !w_sel_boot;
    assign w_sel_int   = (w_a == 16'hFF0F) || (w_a == 16'hFFFF);
    assign w_sel_timer = (w_a >= 16'hFF04) && (w_a <= 16'hFF07);
    assign w_sel_sound = (w_a >= 16'hFF10) && (w_a <= 16'hFF3F);
    assign w_sel_joy   = (w_a == 16'hFF00);

    assign w_boot_idx  = w_a[c_BOOT_AW-1:0];
    assign w_boot_byte = BOOT_IMAGE[{w_boot_idx, 3'b000} +: 8];
    assign w_hram_idx  = w_a[6:0];

    // Pages E0..FF alias the work RAM at C0..DF (echo region).
    assign w_src_page = (dma_reg_q >= 8'hE0) ? (dma_reg_q - 8'h20) : dma_reg_q;
    assign w_src_addr = {w_src_page, 8'h00} + {7'd0, cnt_q};
    assign w_src_vram = (w_src_page[7:5] == 3'b100);
    assign w_oam_addr = 16'hFE00 + {7'd0, cnt_q};

    always_comb begin
        state_d   = state_q;
        dma_reg_d = dma_reg_q;
        cnt_d     = cnt_q;
        dly_d     = dly_q;
        latch_d   = latch_q;
        boot_en_d = boot_en_q;
        unique case (state_q)
            S_IDLE: begin
            end
            S_DELAY: begin
                if (dly_q == 16'(DMA_DELAY - 1)) state_d = S_READ;
                else                              dly_d   = dly_q + 16'd1;
            end
            S_READ: begin
                latch_d = w_src_vram ? bus.Di_ppu : bus.Di;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                cnt_d   = cnt_q + 9'd1;
                state_d = (cnt_q == 9'(DMA_LEN - 1)) ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
        if (w_cpu_wr && w_sel_ff50 && bus.Di_cpu[0]) boot_en_d = 1'b0;
        // A new FF46 write always wins, restarting any transfer in flight.
        if (w_cpu_wr && w_sel_ff46) begin
            dma_reg_d = bus.Di_cpu;
            cnt_d     = '0;
            dly_d     = '0;
            state_d   = (DMA_DELAY == 0) ? S_READ : S_DELAY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dma_reg_q    <= 8'h00;
            latch_q      <= 8'h00;
            cnt_q        <= '0;
            dly_q        <= '0;
            boot_en_q    <= 1'b1;
            dma_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dma_reg_q    <= dma_reg_d;
            latch_q      <= latch_d;
            cnt_q        <= cnt_d;
            dly_q        <= dly_d;
            boot_en_q    <= boot_en_d;
            dma_active_q <= (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clock) begin
        if (w_cpu_wr && w_sel_hram) hram_q[w_hram_idx] <= bus.Di_cpu;
    end

    always_comb begin
        bus.A            = w_a;
        bus.Do           = bus.Di_cpu;
        bus.rd_n         = 1'b1;
        bus.wr_n         = 1'b1;
        bus.cs_n         = 1'b1;
        bus.A_ppu        = w_a;
        bus.Do_ppu       = bus.Di_cpu;
        bus.rd_ppu_n     = 1'b1;
        bus.wr_ppu_n     = 1'b1;
        bus.cs_ppu       = 1'b0;
        bus.cs_interrupt = w_sel_int   && !w_lock;
        bus.cs_timer     = w_sel_timer && !w_lock;
        bus.cs_sound     = w_sel_sound && !w_lock;
        bus.cs_joypad    = w_sel_joy   && !w_lock;
        bus.dma_active   = dma_active_q;
        if (!w_lock) begin
            bus.cs_n     = !w_sel_main;
            bus.rd_n     = bus.rd_cpu_n || !w_sel_main;
            bus.wr_n     = bus.wr_cpu_n || !w_sel_main;
            bus.cs_ppu   = w_sel_ppu;
            bus.rd_ppu_n = bus.rd_cpu_n || !w_sel_ppu;
            bus.wr_ppu_n = bus.wr_cpu_n || !w_sel_ppu;
        end else begin
            bus.A      = w_src_addr;
            bus.A_ppu  = w_oam_addr;
            bus.Do_ppu = latch_q;
            if (state_q == S_READ) begin
                if (w_src_vram) begin
                    bus.A_ppu    = w_src_addr;
                    bus.rd_ppu_n = 1'b0;
                    bus.cs_ppu   = 1'b1;
                end else begin
                    bus.rd_n = 1'b0;
                    bus.cs_n = 1'b0;
                end
            end
            if (state_q == S_WRITE) begin
                bus.wr_ppu_n = 1'b0;
                bus.cs_ppu   = 1'b1;
            end
        end
    end

    // HRAM, FF46 and FF50 stay reachable while the bus is locked by DMA.
    always_comb begin
        bus.Do_cpu = 8'hFF;
        if (w_sel_boot && !w_lock)  bus.Do_cpu = w_boot_byte;
        else if (w_sel_hram)        bus.Do_cpu = hram_q[w_hram_idx];
        else if (w_sel_ff46)        bus.Do_cpu = dma_reg_q;
        else if (w_sel_ff50)        bus.Do_cpu = {7'h7F, ~boot_en_q};
        else if (!w_lock) begin
            if (w_sel_int)             bus.Do_cpu = bus.Do_interrupt;
            else if (w_sel_timer)      bus.Do_cpu = bus.Do_timer;
            else if (w_sel_sound)      bus.Do_cpu = bus.Do_sound;
            else if (w_sel_joy)        bus.Do_cpu = bus.Do_joypad;
            else if (w_sel_ppu)        bus.Do_cpu = bus.Di_ppu;
            else if (w_a < 16'hFE00)   bus.Do_cpu = bus.Di;
        end
    end
endmodule
`default_nettype wire
